// File: rtl/onewire_pkg.sv
// Shared types and timing helper for the 1-wire bus master sequencer.
package onewire_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_BIT   = 2'd1,
        OP_BYTE  = 2'd2,
        OP_NOP   = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        IDLE,
        RST_LOW,
        RST_HIGH,
        RST_TAIL,
        SLOT_LOW,
        SLOT_DRV,
        SLOT_TAIL,
        SLOT_REC,
        RESP
    } state_t;

    function automatic int us2cyc(input int us, input int clk_per_us);
        return us * clk_per_us;
    endfunction

endpackage

// File: rtl/onewire_if.sv
// Command/response handshake plus pad signals between the host side and the controller.
interface onewire_if;
    import onewire_pkg::*;

    // Both channels transfer on a cycle where valid && ready; the sender holds
    // its payload stable while valid is high and ready is low.
    logic       cmd_valid;
    logic       cmd_ready;
    op_t        cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       owr_pull;
    logic       owr_in;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, owr_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, owr_pull
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, owr_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, owr_pull
    );

endinterface

// File: rtl/onewire_timer.sv
// Loadable down-counter; done flags the cycle the count sits at zero.
module onewire_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/onewire_ctrl.sv
// 1-wire bus master: sequences RESET/BIT/BYTE slot timing and returns presence or read data.
module onewire_ctrl
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US = 50,
    parameter int T_RSTL     = 480,
    parameter int T_RSTH     = 480,
    parameter int T_RSTP     = 70,
    parameter int T_DAT0     = 60,
    parameter int T_DAT1     = 6,
    parameter int T_DATS     = 15,
    parameter int T_REC      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    onewire_if.slave   bus,
    output state_t     o_dbg_state
);

    localparam int T_MAX = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
    localparam int TW    = $clog2(T_MAX * CLK_PER_US);

    // Each segment loads N*CLK_PER_US-1 so it lasts exactly N*CLK_PER_US cycles.
    localparam logic [TW-1:0] C_RSTL = TW'(us2cyc(T_RSTL, CLK_PER_US) - 1);
    localparam logic [TW-1:0] C_RSTP = TW'(us2cyc(T_RSTP, CLK_PER_US) - 1);
    localparam logic [TW-1:0] C_RSTT = TW'(us2cyc(T_RSTH - T_RSTP, CLK_PER_US) - 1);
    localparam logic [TW-1:0] C_DAT1 = TW'(us2cyc(T_DAT1, CLK_PER_US) - 1);
    localparam logic [TW-1:0] C_DRV  = TW'(us2cyc(T_DATS - T_DAT1, CLK_PER_US) - 1);
    localparam logic [TW-1:0] C_TAIL = TW'(us2cyc(T_DAT0 - T_DATS, CLK_PER_US) - 1);
    localparam logic [TW-1:0] C_REC  = TW'(us2cyc(T_REC, CLK_PER_US) - 1);

    state_t     r_state;
    op_t        r_op;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_pull;
    logic       r_cmd_ready;
    logic       r_rsp_valid;
    logic       r_presence;
    logic       r_rbit;
    logic [2:0] r_slot;
    logic [7:0] r_shift;
    logic [7:0] r_rsp_data;

    logic          w_accept;
    logic          w_done;
    logic          w_load;
    logic [TW-1:0] w_value;

    assign w_accept = bus.cmd_valid && r_cmd_ready;

    // Timer is reloaded on the same edge that moves the FSM into the next segment.
    always_comb begin
        w_load  = 1'b0;
        w_value = C_DAT1;
        case (r_state)
            IDLE: begin
                w_load  = w_accept && (bus.cmd_op != OP_NOP);
                w_value = (bus.cmd_op == OP_RESET) ? C_RSTL : C_DAT1;
            end
            RST_LOW:   begin w_load = w_done; w_value = C_RSTP; end
            RST_HIGH:  begin w_load = w_done; w_value = C_RSTT; end
            SLOT_LOW:  begin w_load = w_done; w_value = C_DRV;  end
            SLOT_DRV:  begin w_load = w_done; w_value = C_TAIL; end
            SLOT_TAIL: begin w_load = w_done; w_value = C_REC;  end
            SLOT_REC:  begin w_load = w_done; w_value = C_DAT1; end
            default:   ;
        endcase
    end

    onewire_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .value (w_value),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= OP_NOP;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_pull      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_presence  <= 1'b0;
            r_rbit      <= 1'b0;
            r_slot      <= 3'd0;
            r_shift     <= 8'd0;
            r_rsp_data  <= 8'd0;
        end else begin
            r_sync1 <= bus.owr_in;
            r_sync2 <= r_sync1;
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= bus.cmd_op;
                        r_shift     <= bus.cmd_data;
                        r_slot      <= 3'd0;
                        r_presence  <= 1'b0;
                        r_rsp_data  <= 8'd0;
                        case (bus.cmd_op)
                            OP_RESET: begin r_state <= RST_LOW;  r_pull <= 1'b1; end
                            OP_BIT,
                            OP_BYTE:  begin r_state <= SLOT_LOW; r_pull <= 1'b1; end
                            default:  begin r_state <= RESP;     r_rsp_valid <= 1'b1; end
                        endcase
                    end
                end
                RST_LOW: if (w_done) begin
                    r_state <= RST_HIGH;
                    r_pull  <= 1'b0;
                end
                RST_HIGH: if (w_done) begin
                    r_presence <= !r_sync2;
                    r_state    <= RST_TAIL;
                end
                RST_TAIL: if (w_done) begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                end
                SLOT_LOW: if (w_done) begin
                    r_state <= SLOT_DRV;
                    r_pull  <= !r_shift[0];
                end
                SLOT_DRV: if (w_done) begin
                    r_rbit  <= r_sync2;
                    r_state <= SLOT_TAIL;
                end
                SLOT_TAIL: if (w_done) begin
                    r_state <= SLOT_REC;
                    r_pull  <= 1'b0;
                end
                SLOT_REC: if (w_done) begin
                    // Shift only after recovery so r_shift[0] stays the write bit for the whole slot.
                    if (r_op == OP_BYTE && r_slot != 3'd7) begin
                        r_slot  <= r_slot + 3'd1;
                        r_shift <= {r_rbit, r_shift[7:1]};
                        r_pull  <= 1'b1;
                        r_state <= SLOT_LOW;
                    end else begin
                        r_rsp_data  <= (r_op == OP_BYTE) ? {r_rbit, r_shift[7:1]} : {7'd0, r_rbit};
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_presence = r_presence;
    assign bus.owr_pull     = r_pull;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_onewire_ctrl.sv
// Randomized bench for onewire_ctrl with a model slave on the bus and a timing-level reference model.
module tb_onewire_ctrl;
    import onewire_pkg::*;

    localparam int C    = 10;
    localparam int SLOT = (60 + 5) * C;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    onewire_if ifc();

    onewire_ctrl #(.CLK_PER_US(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifc),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Open-drain bus: low when either the master or the model slave pulls.
    logic       slave_low;
    int         slave_mode;   // 0 silent, 1 presence pulse after reset, 2 hold low in masked slots
    logic [7:0] slave_mask;
    int         slave_slot;

    assign ifc.owr_in = ~(ifc.owr_pull | slave_low);

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_start_q[$];
    logic [15:0] exp_len_q[$];
    logic [15:0] obs_start_q[$];
    logic [15:0] obs_len_q[$];

    initial begin
        slave_low = 1'b0;
        forever begin
            @(posedge ifc.owr_pull);
            if (slave_mode == 2) begin
                if (slave_mask[slave_slot[2:0]]) begin
                    slave_low = 1'b1;
                    repeat (30 * C) @(negedge clk);
                    slave_low = 1'b0;
                end
                slave_slot++;
            end else if (slave_mode == 1) begin
                @(negedge ifc.owr_pull);
                repeat ($urandom_range(60 * C, 15 * C)) @(negedge clk);
                slave_low = 1'b1;
                repeat ($urandom_range(120 * C, 60 * C)) @(negedge clk);
                slave_low = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: low pulses and response derived directly from the slot timing rules.
    task automatic model(input op_t op, input logic [7:0] data, input logic [7:0] mask,
                         input logic present, output logic [7:0] e_data,
                         output logic e_pres, output int e_lat);
        int nb;
        exp_start_q.delete();
        exp_len_q.delete();
        e_data = 8'd0;
        e_pres = 1'b0;
        e_lat  = 0;
        nb     = (op == OP_BYTE) ? 8 : 1;
        case (op)
            OP_RESET: begin
                exp_start_q.push_back(16'd0);
                exp_len_q.push_back(16'(480 * C));
                e_lat  = (480 + 480) * C;
                e_pres = present;
            end
            OP_BIT, OP_BYTE: begin
                for (int i = 0; i < nb; i++) begin
                    exp_start_q.push_back(16'(i * SLOT));
                    exp_len_q.push_back(data[i] ? 16'(6 * C) : 16'(60 * C));
                    e_data[i] = data[i] & ~mask[i];
                end
                e_lat = nb * SLOT;
            end
            default: e_lat = 0;
        endcase
    endtask

    task automatic send_cmd(input op_t op, input logic [7:0] data);
        int n;
        ifc.cmd_op    = op;
        ifc.cmd_data  = data;
        ifc.cmd_valid = 1'b1;
        n = 0;
        while (!ifc.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 100), 32'd1);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    // Called on the first negedge after the accepting edge; records pulses until rsp_valid.
    task automatic capture(output int lat);
        logic prev;
        int   rs;
        obs_start_q.delete();
        obs_len_q.delete();
        prev = 1'b0;
        rs   = 0;
        lat  = -1;
        for (int i = 0; i < 14000; i++) begin
            if (ifc.owr_pull && !prev) rs = i;
            if (!ifc.owr_pull && prev) begin
                obs_start_q.push_back(16'(rs));
                obs_len_q.push_back(16'(i - rs));
            end
            prev = ifc.owr_pull;
            if (ifc.rsp_valid) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input op_t op, input logic [7:0] data, input logic [7:0] mask,
                          input logic present);
        logic [7:0] e_data;
        logic       e_pres;
        int         e_lat;
        int         lat;
        string      nm;
        nm = op.name();
        model(op, data, mask, present, e_data, e_pres, e_lat);
        slave_slot = 0;
        slave_mask = mask;
        slave_mode = (op == OP_RESET) ? (present ? 1 : 0) : 2;
        send_cmd(op, data);
        capture(lat);
        check({nm, "_latency"}, lat, e_lat);
        check({nm, "_npulses"}, obs_start_q.size(), exp_start_q.size());
        for (int i = 0; i < exp_start_q.size() && i < obs_start_q.size(); i++) begin
            check($sformatf("%s_pulse%0d_start", nm, i), obs_start_q[i], exp_start_q[i]);
            check($sformatf("%s_pulse%0d_width", nm, i), obs_len_q[i], exp_len_q[i]);
        end
        check({nm, "_rsp_data"}, ifc.rsp_data, e_data);
        check({nm, "_presence"}, ifc.rsp_presence, e_pres);
    endtask

    task automatic finish_rsp(input int delay);
        logic [7:0] held;
        logic       held_p;
        logic       ok;
        held   = ifc.rsp_data;
        held_p = ifc.rsp_presence;
        ok     = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (ifc.rsp_valid !== 1'b1 || ifc.rsp_data !== held ||
                ifc.rsp_presence !== held_p || ifc.cmd_ready !== 1'b0) ok = 1'b0;
        end
        check("rsp_hold", ok, 1'b1);
        ifc.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", ifc.rsp_valid, 1'b0);
        check("ready_after_rsp", ifc.cmd_ready, 1'b1);
        ifc.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   lat;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = OP_NOP;
        ifc.cmd_data  = 8'd0;
        ifc.rsp_ready = 1'b0;
        slave_mode    = 0;
        slave_mask    = 8'd0;
        slave_slot    = 0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", ifc.cmd_ready, 1'b0);
        check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
        check("rst_owr_pull", ifc.owr_pull, 1'b0);
        check("rst_rsp_data", ifc.rsp_data, 8'd0);
        check("rst_presence", ifc.rsp_presence, 1'b0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ifc.cmd_ready, 1'b1);

        run_op(OP_RESET, 8'd0, 8'd0, 1'b1);
        finish_rsp($urandom_range(4, 1));
        run_op(OP_RESET, 8'd0, 8'd0, 1'b0);
        finish_rsp($urandom_range(4, 1));

        run_op(OP_BYTE, 8'hA5, 8'h00, 1'b0);
        finish_rsp($urandom_range(4, 1));
        run_op(OP_BYTE, 8'hFF, 8'h42, 1'b0);
        finish_rsp($urandom_range(4, 1));
        for (int k = 0; k < 2; k++) begin
            run_op(OP_BYTE, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
            finish_rsp($urandom_range(4, 1));
        end
        for (int k = 0; k < 4; k++) begin
            run_op(OP_BIT, 8'($urandom_range(255, 0)), 8'($urandom_range(1, 0)), 1'b0);
            finish_rsp($urandom_range(4, 1));
        end

        // Long response stall with a stray command offered meanwhile.
        run_op(OP_BIT, 8'h01, 8'h00, 1'b0);
        fork
            begin
                repeat (50) @(negedge clk);
                ifc.cmd_op    = OP_RESET;
                ifc.cmd_valid = 1'b1;
                @(negedge clk);
                ifc.cmd_valid = 1'b0;
            end
        join_none
        finish_rsp(100);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifc.owr_pull || ifc.rsp_valid) ok = 1'b0;
        end
        check("stray_cmd_ignored", ok, 1'b1);

        run_op(OP_NOP, 8'h5A, 8'h00, 1'b0);
        finish_rsp($urandom_range(4, 1));
        ifc.rsp_ready = 1'b1;
        send_cmd(OP_NOP, 8'hC3);
        capture(lat);
        check("nop_fast_latency", lat, 0);
        check("nop_fast_npulses", obs_start_q.size(), 0);
        check("nop_fast_data", ifc.rsp_data, 8'd0);
        @(negedge clk);
        check("nop_fast_one_cycle", ifc.rsp_valid, 1'b0);
        check("nop_fast_ready", ifc.cmd_ready, 1'b1);
        ifc.rsp_ready = 1'b0;

        // Abort a BYTE inside slot 3 and make sure the block recovers cleanly.
        slave_mode = 0;
        send_cmd(OP_BYTE, 8'($urandom_range(255, 0)));
        repeat (3 * SLOT + 30) @(negedge clk);
        check("abort_pull_before", ifc.owr_pull, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("abort_pull_async", ifc.owr_pull, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_ready_in_reset", ifc.cmd_ready, 1'b0);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifc.rsp_valid || ifc.owr_pull) ok = 1'b0;
        end
        check("abort_no_response", ok, 1'b1);
        check("abort_ready", ifc.cmd_ready, 1'b1);
        run_op(OP_RESET, 8'd0, 8'd0, 1'b1);
        finish_rsp($urandom_range(4, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
